// File: rtl/send_controller_if.sv
// Handshake bundle between send_controller and its neighbours (total controller,
// fragment_pkt, recv_controller). The master side drives requests and ACK information.
interface send_controller_if #(
    parameter int DFX_WIDTH     = 2,
    parameter int SEQ_NUM_WIDTH = 1
);
    logic [DFX_WIDTH-1:0]     local_dfx;
    logic                     valid_send_req;
    logic [DFX_WIDTH-1:0]     dst_dfx_req;
    logic                     ready_send_req;
    logic                     send_done;
    logic                     send_fail;
    logic                     start_cre_data_pkt;
    logic [DFX_WIDTH-1:0]     src_dfx_data_pkt_send;
    logic [DFX_WIDTH-1:0]     dst_dfx_data_pkt_send;
    logic [SEQ_NUM_WIDTH-1:0] sn_data_pkt_send;
    logic                     create_done_data_pkt;
    logic                     valid_ack_pkt_recv;
    logic [SEQ_NUM_WIDTH-1:0] rn_ack_pkt_recv;
    logic [DFX_WIDTH-1:0]     src_dfx_ack_pkt_recv;
    logic                     wait_ack_pkt_recv;

    modport master (
        output local_dfx, valid_send_req, dst_dfx_req, create_done_data_pkt,
               valid_ack_pkt_recv, rn_ack_pkt_recv, src_dfx_ack_pkt_recv,
        input  ready_send_req, send_done, send_fail, start_cre_data_pkt,
               src_dfx_data_pkt_send, dst_dfx_data_pkt_send, sn_data_pkt_send,
               wait_ack_pkt_recv
    );

    modport slave (
        input  local_dfx, valid_send_req, dst_dfx_req, create_done_data_pkt,
               valid_ack_pkt_recv, rn_ack_pkt_recv, src_dfx_ack_pkt_recv,
        output ready_send_req, send_done, send_fail, start_cre_data_pkt,
               src_dfx_data_pkt_send, dst_dfx_data_pkt_send, sn_data_pkt_send,
               wait_ack_pkt_recv
    );
endinterface

// File: rtl/send_controller.sv
// Stop-and-wait ARQ transmit controller for one router lane: send, await ACK, retransmit on timeout.
// Define SEND_CTRL_RETRY_LIMIT_EN to bound retransmissions by MAX_RETRY and enable the FAIL exit.
module send_controller #(
    parameter int DFX_WIDTH      = 2,
    parameter int SEQ_NUM_WIDTH  = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMER_WIDTH    = 16,
    parameter int MAX_RETRY      = 7,
    parameter int RETRY_WIDTH    = 3
) (
    input  logic             clk,
    input  logic             rst,
    send_controller_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_PKT,
        WAIT_CREATE,
        WAIT_ACK,
        DONE,
        FAIL
    } state_e;

    if ((TIMEOUT_CYCLES < 2) || (((TIMEOUT_CYCLES - 1) >> TIMER_WIDTH) != 0) ||
        ((MAX_RETRY >> RETRY_WIDTH) != 0)) begin : g_bad_cfg
        $error("send_controller: TIMER_WIDTH/RETRY_WIDTH too small or TIMEOUT_CYCLES < 2");
    end

    state_e                   state_q, state_d;
    logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
    logic [SEQ_NUM_WIDTH-1:0] sn_q, sn_d, sn_next;
    logic                     ready_q, ready_d;
    logic                     start_q, start_d;
    logic                     done_q, done_d;
    logic                     wait_q;
    logic [DFX_WIDTH-1:0]     src_q, src_d;
    logic [DFX_WIDTH-1:0]     dst_q, dst_d;
    logic [SEQ_NUM_WIDTH-1:0] pkt_sn_q, pkt_sn_d;
    logic                     accept;
    logic                     ack_match;
    logic                     timeout;
`ifdef SEND_CTRL_RETRY_LIMIT_EN
    logic [RETRY_WIDTH-1:0]   retry_q, retry_d;
    logic                     fail_q, fail_d;
`endif

    assign sn_next   = sn_q + SEQ_NUM_WIDTH'(1);
    // ready_q is only ever high in IDLE, so it doubles as the accept qualifier.
    assign accept    = bus.valid_send_req && ready_q;
    assign ack_match = (state_q == WAIT_ACK) && bus.valid_ack_pkt_recv && wait_q &&
                       (bus.src_dfx_ack_pkt_recv == dst_q) &&
                       (bus.rn_ack_pkt_recv == sn_next);
    assign timeout   = (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every next-state variable gets a default before the case, so no path infers a latch.
        state_d  = state_q;
        timer_d  = timer_q;
        sn_d     = sn_q;
        src_d    = src_q;
        dst_d    = dst_q;
        pkt_sn_d = pkt_sn_q;
`ifdef SEND_CTRL_RETRY_LIMIT_EN
        retry_d  = retry_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND_PKT;
`ifdef SEND_CTRL_RETRY_LIMIT_EN
                    retry_d = '0;
`endif
                end
            end
            SEND_PKT: state_d = WAIT_CREATE;
            WAIT_CREATE: begin
                if (bus.create_done_data_pkt) begin
                    timer_d = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                timer_d = timer_q + TIMER_WIDTH'(1);
                // A matching ACK on the timeout cycle still completes the transfer.
                if (ack_match) begin
                    sn_d    = sn_next;
                    state_d = DONE;
                end else if (timeout) begin
`ifdef SEND_CTRL_RETRY_LIMIT_EN
                    if (retry_q == RETRY_WIDTH'(MAX_RETRY)) begin
                        state_d = FAIL;
                    end else begin
                        retry_d = retry_q + RETRY_WIDTH'(1);
                        state_d = SEND_PKT;
                    end
`else
                    state_d = SEND_PKT;
`endif
                end
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they change on the same edge as it.
        ready_d = (state_d == IDLE);
        start_d = (state_d == SEND_PKT);
        done_d  = (state_d == DONE);
`ifdef SEND_CTRL_RETRY_LIMIT_EN
        fail_d  = (state_d == FAIL);
`endif

        if (accept) begin
            src_d = bus.local_dfx;
            dst_d = bus.dst_dfx_req;
        end else if (state_d == IDLE) begin
            src_d = '0;
            dst_d = '0;
        end

        if (state_d == SEND_PKT) begin
            pkt_sn_d = sn_q;
        end else if (state_d == IDLE) begin
            pkt_sn_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments; reset is synchronous and acts only on an edge.
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            sn_q     <= '0;
            ready_q  <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            wait_q   <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            pkt_sn_q <= '0;
`ifdef SEND_CTRL_RETRY_LIMIT_EN
            retry_q  <= '0;
            fail_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            sn_q     <= sn_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            done_q   <= done_d;
            wait_q   <= 1'b1;
            src_q    <= src_d;
            dst_q    <= dst_d;
            pkt_sn_q <= pkt_sn_d;
`ifdef SEND_CTRL_RETRY_LIMIT_EN
            retry_q  <= retry_d;
            fail_q   <= fail_d;
`endif
        end
    end

    assign bus.ready_send_req        = ready_q;
    assign bus.send_done             = done_q;
    assign bus.start_cre_data_pkt    = start_q;
    assign bus.src_dfx_data_pkt_send = src_q;
    assign bus.dst_dfx_data_pkt_send = dst_q;
    assign bus.sn_data_pkt_send      = pkt_sn_q;
    assign bus.wait_ack_pkt_recv     = wait_q;
`ifdef SEND_CTRL_RETRY_LIMIT_EN
    assign bus.send_fail             = fail_q;
`else
    assign bus.send_fail             = 1'b0;
`endif

endmodule

// File: tb/tb_send_controller.sv
// Directed bench for send_controller: cycle table for the basic ARQ flow, hand sequences
// for timeout/retry, ACK-on-timeout and mid-transfer reset (both SEND_CTRL_RETRY_LIMIT_EN builds).
module tb_send_controller;

    localparam int DFX_WIDTH      = 2;
    localparam int SEQ_NUM_WIDTH  = 1;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int TIMER_WIDTH    = 8;
    localparam int MAX_RETRY      = 2;
    localparam int RETRY_WIDTH    = 2;
    localparam int NVEC           = 25;

    logic clk = 1'b0;
    logic rst;

    send_controller_if #(.DFX_WIDTH(DFX_WIDTH), .SEQ_NUM_WIDTH(SEQ_NUM_WIDTH)) bus ();

    send_controller #(
        .DFX_WIDTH     (DFX_WIDTH),
        .SEQ_NUM_WIDTH (SEQ_NUM_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMER_WIDTH   (TIMER_WIDTH),
        .MAX_RETRY     (MAX_RETRY),
        .RETRY_WIDTH   (RETRY_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       vld;
        logic [1:0] dst;
        logic       cd;
        logic       av;
        logic       rn;
        logic [1:0] asrc;
        logic       e_ready;
        logic       e_start;
        logic       e_done;
        logic       fld;
        logic [1:0] e_src;
        logic [1:0] e_dst;
        logic       e_sn;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic vld, input logic [1:0] dst, input logic cd,
                                input logic av, input logic rn, input logic [1:0] asrc,
                                input logic e_ready, input logic e_start, input logic e_done,
                                input logic fld, input logic [1:0] e_src,
                                input logic [1:0] e_dst, input logic e_sn);
        vec_t v;
        v.vld = vld; v.dst = dst; v.cd = cd; v.av = av; v.rn = rn; v.asrc = asrc;
        v.e_ready = e_ready; v.e_start = e_start; v.e_done = e_done;
        v.fld = fld; v.e_src = e_src; v.e_dst = e_dst; v.e_sn = e_sn;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [1:0] dst, input logic cd,
                         input logic av, input logic rn, input logic [1:0] asrc);
        bus.valid_send_req       = vld;
        bus.dst_dfx_req          = dst;
        bus.create_done_data_pkt = cd;
        bus.valid_ack_pkt_recv   = av;
        bus.rn_ack_pkt_recv      = rn;
        bus.src_dfx_ack_pkt_recv = asrc;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    // Called just after a start pulse; leaves the DUT freshly in WAIT_ACK.
    task automatic create_pkt();
        idle();
        tick();
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        tick();
        idle();
    endtask

    // Counts cycles from WAIT_ACK entry to the next start or fail pulse, feeding two
    // non-matching ACKs (wrong rn, wrong src) along the way. Assumes sn=0, dst=2.
    task automatic wait_pulse(input string tag, output int n, output logic got_fail);
        int bad_wait;
        n        = 0;
        got_fail = 1'b0;
        bad_wait = 0;
        while (n < 40) begin
            if (n == 2)      drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd2);
            else if (n == 5) drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd1);
            else             idle();
            tick();
            n++;
            if (bus.wait_ack_pkt_recv !== 1'b1) bad_wait++;
            if (bus.send_done === 1'b1) bad_wait++;
            if (bus.start_cre_data_pkt === 1'b1 || bus.send_fail === 1'b1) break;
        end
        got_fail = bus.send_fail;
        idle();
        check({tag, ".wait_no_done"}, bad_wait, 0);
    endtask

    // Matching ACK (rn=1, src=2) presented exactly on the timeout cycle.
    task automatic ack_on_timeout();
        int pulses;
        pulses = 0;
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
            idle();
            tick();
            pulses += int'(bus.start_cre_data_pkt) + int'(bus.send_done) + int'(bus.send_fail);
        end
        check("tmo_ack.quiet", pulses, 0);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd2);
        tick();
        check("tmo_ack.done", bus.send_done, 1);
        check("tmo_ack.no_start", bus.start_cre_data_pkt, 0);
        check("tmo_ack.no_fail", bus.send_fail, 0);
        idle();
        tick();
        check("tmo_ack.no_retx", bus.start_cre_data_pkt, 0);
        check("tmo_ack.ready", bus.ready_send_req, 1);
        check("tmo_ack.done_end", bus.send_done, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ready"}, bus.ready_send_req, 0);
        check({tag, ".wait"},  bus.wait_ack_pkt_recv, 0);
        check({tag, ".start"}, bus.start_cre_data_pkt, 0);
        check({tag, ".done"},  bus.send_done, 0);
        check({tag, ".fail"},  bus.send_fail, 0);
        check({tag, ".src"},   bus.src_dfx_data_pkt_send, 0);
        check({tag, ".dst"},   bus.dst_dfx_data_pkt_send, 0);
        check({tag, ".sn"},    bus.sn_data_pkt_send, 0);
    endtask

    initial begin
        int   n;
        logic f;

        // Table: inputs during the cycle, outputs after the following edge. local_dfx = 1.
        vecs[0]  = mk(1, 2, 0, 0, 0, 0,  0, 1, 0, 1, 1, 2, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2, 0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 2, 0);
        vecs[4]  = mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2, 0);
        vecs[6]  = mk(0, 0, 0, 1, 0, 2,  0, 0, 0, 1, 1, 2, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2, 0);
        vecs[8]  = mk(0, 0, 0, 1, 1, 3,  0, 0, 0, 1, 1, 2, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2, 0);
        vecs[13] = mk(0, 0, 0, 1, 1, 2,  0, 0, 1, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
        vecs[15] = mk(1, 3, 0, 0, 0, 0,  0, 1, 0, 1, 1, 3, 1);
        vecs[16] = mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 3, 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 3, 1);
        vecs[18] = mk(0, 0, 0, 1, 0, 3,  0, 0, 0, 1, 1, 3, 1);
        vecs[19] = mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 3, 1);
        vecs[20] = mk(0, 0, 0, 1, 0, 3,  0, 0, 1, 0, 0, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
        vecs[22] = mk(1, 2, 0, 0, 0, 0,  0, 1, 0, 1, 1, 2, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2, 0);
        vecs[24] = mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 2, 0);

        bus.local_dfx = 2'd1;
        rst = 1'b1;
        idle();
        repeat (3) tick();
        check_all_zero("reset");

        rst = 1'b0;
        tick();
        check("post_reset.ready", bus.ready_send_req, 1);
        check("post_reset.wait",  bus.wait_ack_pkt_recv, 1);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].vld, vecs[i].dst, vecs[i].cd, vecs[i].av, vecs[i].rn, vecs[i].asrc);
            tick();
            check($sformatf("v%0d.ready", i), bus.ready_send_req, vecs[i].e_ready);
            check($sformatf("v%0d.start", i), bus.start_cre_data_pkt, vecs[i].e_start);
            check($sformatf("v%0d.done", i),  bus.send_done, vecs[i].e_done);
            check($sformatf("v%0d.fail", i),  bus.send_fail, 0);
            check($sformatf("v%0d.wait", i),  bus.wait_ack_pkt_recv, 1);
            if (vecs[i].fld) begin
                check($sformatf("v%0d.src", i), bus.src_dfx_data_pkt_send, vecs[i].e_src);
                check($sformatf("v%0d.dst", i), bus.dst_dfx_data_pkt_send, vecs[i].e_dst);
                check($sformatf("v%0d.sn", i),  bus.sn_data_pkt_send, vecs[i].e_sn);
            end
        end
        idle();

        // Now in WAIT_ACK with sn=0, dst=2: let it time out twice.
        for (int r = 1; r <= 2; r++) begin
            wait_pulse($sformatf("retx%0d", r), n, f);
            check($sformatf("retx%0d.delay", r), n, TIMEOUT_CYCLES);
            check($sformatf("retx%0d.start", r), bus.start_cre_data_pkt, 1);
            check($sformatf("retx%0d.nofail", r), f, 0);
            check($sformatf("retx%0d.dst", r), bus.dst_dfx_data_pkt_send, 2);
            check($sformatf("retx%0d.src", r), bus.src_dfx_data_pkt_send, 1);
            check($sformatf("retx%0d.sn", r), bus.sn_data_pkt_send, 0);
            create_pkt();
        end

        wait_pulse("third", n, f);
        check("third.delay", n, TIMEOUT_CYCLES);
`ifdef SEND_CTRL_RETRY_LIMIT_EN
        check("fail.pulse", f, 1);
        check("fail.no_start", bus.start_cre_data_pkt, 0);
        tick();
        check("fail.end", bus.send_fail, 0);
        check("fail.ready", bus.ready_send_req, 1);
        check("fail.dst_cleared", bus.dst_dfx_data_pkt_send, 0);
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        check("after_fail.start", bus.start_cre_data_pkt, 1);
        check("after_fail.sn", bus.sn_data_pkt_send, 0);
        create_pkt();
`else
        check("no_limit.start", bus.start_cre_data_pkt, 1);
        check("no_limit.nofail", f, 0);
        check("no_limit.sn", bus.sn_data_pkt_send, 0);
        create_pkt();
`endif

        ack_on_timeout();

        // sn advanced to 1; then a reset in WAIT_ACK must abort silently and clear sn.
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        check("send_sn1.start", bus.start_cre_data_pkt, 1);
        check("send_sn1.sn", bus.sn_data_pkt_send, 1);
        check("send_sn1.dst", bus.dst_dfx_data_pkt_send, 1);
        create_pkt();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_all_zero("mid_rst");
        tick();
        check("mid_rst2.done", bus.send_done, 0);
        check("mid_rst2.fail", bus.send_fail, 0);
        rst = 1'b0;
        tick();
        check("rst_rel.ready", bus.ready_send_req, 1);
        check("rst_rel.wait", bus.wait_ack_pkt_recv, 1);
        check("rst_rel.done", bus.send_done, 0);
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        check("rst_rel.start", bus.start_cre_data_pkt, 1);
        check("rst_rel.sn", bus.sn_data_pkt_send, 0);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/send_controller.md
# send_controller

Transmit-side stop-and-wait ARQ controller for one router lane. Accepts a send request from the total controller and triggers data-packet creation in fragment_pkt with the current sequence number. It then waits for the matching ACK delivered by recv_controller and retransmits on timeout. It completes with a done pulse, or with a fail pulse once the retry budget is exhausted.

## Interface
- DFX_WIDTH, 2, source/destination DFX address width
- SEQ_NUM_WIDTH, 1, sequence/request number width
- TIMEOUT_CYCLES, 1024, ACK wait window in clk cycles (≥2)
- TIMER_WIDTH, 16, timer width; must hold TIMEOUT_CYCLES-1
- MAX_RETRY, 7, retransmissions allowed before fail
- RETRY_WIDTH, 3, retry counter width; must hold MAX_RETRY

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- local_dfx  in  DFX_WIDTH  own node address
- valid_send_req  in  1  total controller requests a data send
- dst_dfx_req  in  DFX_WIDTH  destination of requested send
- ready_send_req  out  1  controller idle, request accepted when valid&&ready
- send_done  out  1  one-cycle pulse, ACK received
- send_fail  out  1  one-cycle pulse, retries exhausted
- start_cre_data_pkt  out  1  one-cycle pulse to fragment_pkt
- src_dfx_data_pkt_send  out  DFX_WIDTH  = local_dfx captured at accept
- dst_dfx_data_pkt_send  out  DFX_WIDTH  = captured dst_dfx_req
- sn_data_pkt_send  out  SEQ_NUM_WIDTH  sequence number of packet
- create_done_data_pkt  in  1  fragment_pkt finished creating packet
- valid_ack_pkt_recv  in  1  ACK info valid from recv_controller
- rn_ack_pkt_recv  in  SEQ_NUM_WIDTH  request number carried by ACK
- src_dfx_ack_pkt_recv  in  DFX_WIDTH  sender of the ACK
- wait_ack_pkt_recv  out  1  ready for ACK info; ACK consumed when valid&&wait

## Operation
- States: IDLE, SEND_PKT, WAIT_CREATE, WAIT_ACK, DONE, FAIL.
- IDLE: ready_send_req=1. On valid&&ready → capture dst_dfx_req, local_dfx; retry_cnt=0; go SEND_PKT.
- SEND_PKT: start_cre_data_pkt=1 for this single cycle; go WAIT_CREATE.
- WAIT_CREATE: hold packet fields. On create_done_data_pkt → timer=0, go WAIT_ACK.
- WAIT_ACK: timer increments by 1 each cycle.
  - Matching ACK: valid&&wait, src_dfx_ack_pkt_recv==captured dst, and rn_ack_pkt_recv==(sn+1) mod 2^SEQ_NUM_WIDTH. On match → sn<=sn+1 (wraps), go DONE.
  - Timeout: timer==TIMEOUT_CYCLES-1 with no match. If retry_cnt==MAX_RETRY → go FAIL; else retry_cnt++, go SEND_PKT with sn unchanged.
- DONE: send_done=1 for one cycle, go IDLE. FAIL: send_fail=1 for one cycle, sn unchanged, go IDLE.
- wait_ack_pkt_recv=1 in every state after reset, so recv_controller never stalls. ACKs consumed outside WAIT_ACK, or non-matching ACKs, are dropped with no state change.
- Packet output fields hold their values from SEND_PKT through WAIT_ACK and are cleared to 0 in IDLE.

## Timing
- All outputs are registered and update on the same edge as the state.
- Reset values: ready_send_req=0, send_done=0, send_fail=0, start_cre_data_pkt=0, all dfx/sn outputs=0, wait_ack_pkt_recv=0; internal sn=0, timer=0, retry_cnt=0, state IDLE. The first cycle after rst deasserts has ready_send_req=1 and wait_ack_pkt_recv=1.
- Accept sampled at edge T → start_cre_data_pkt high in cycle T+1, ready_send_req low from T+1.
- Timeout fires TIMEOUT_CYCLES cycles after entering WAIT_ACK. The retransmit start pulse follows on the next cycle.
- Matching ACK at edge A → send_done high in cycle A+1, ready_send_req high in A+2.
- A matching ACK in the same cycle as timeout: the ACK wins, with no retry or fail.
- create_done_data_pkt is ignored outside WAIT_CREATE.
- rst asserted in any state aborts the transfer in the next cycle: no done or fail pulse, sn returns to 0.

## Configuration
- SEND_CTRL_RETRY_LIMIT_EN defined: retry_cnt and MAX_RETRY are enforced as above, and FAIL is reachable.
- Undefined: no retry counter; every timeout retransmits indefinitely, FAIL is never entered, and send_fail is tied 0.

## Test plan
- Reset then request dst=2, local=1; create_done after 3 cycles; ACK rn=1, src=2 after 10 cycles → one start pulse with sn=0, send_done pulse, next send uses sn=1.
- Two back-to-back successful sends → second ACK must carry rn=0 (wrap); sn returns to 0.
- No ACK, TIMEOUT_CYCLES=16 → retransmit pulse exactly 16 cycles after entering WAIT_ACK with identical dst and sn.
- ACK with wrong rn (=sn) or wrong src → consumed (wait=1), ignored, timeout still fires.
- With SEND_CTRL_RETRY_LIMIT_EN, MAX_RETRY=2, no ACK → 3 start pulses, then send_fail pulse, ready high, sn unchanged; without the macro → pulses continue, no fail.
- Matching ACK on the timeout cycle → send_done, no retransmit. rst mid-WAIT_ACK → outputs return to reset values, no pulses.
